// File: rtl/sysarr_defs.sv
// Shared definitions for the systolic-array sequencer: default geometry, FSM state encodings
// and the array pipeline latency formula.
package sysarr_defs;

    localparam int unsigned WORD_LEN_DEF = 4;
    localparam int unsigned ARR_WDT_DEF  = 4;
    localparam int unsigned ARR_HGT_DEF  = 4;
    localparam int unsigned CNT_W_DEF    = 16;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StSwap   = 3'd2,
        StStream = 3'd3,
        StDrain  = 3'd4
    } sysarr_state_e;

    // A vector entering the west edge reaches the south edge of the far column after this many cycles.
    function automatic int unsigned calc_lat(input int unsigned hgt, input int unsigned wdt);
        return hgt + wdt - 1;
    endfunction

endpackage

// File: rtl/sysarr_ctrl_if.sv
// Host/DMA <-> sequencer <-> array signal bundle. The stall_cnt member exists only when
// SYSARR_CTRL_PERF_EN is defined.
interface sysarr_ctrl_if #(
    parameter int unsigned WORD_LEN = sysarr_defs::WORD_LEN_DEF,
    parameter int unsigned ARR_HGT  = sysarr_defs::ARR_HGT_DEF,
    parameter int unsigned CNT_W    = sysarr_defs::CNT_W_DEF
);
    logic                         start;
    logic [CNT_W-1:0]             n_vec;
    logic                         busy;
    logic                         done;
    logic                         w_valid;
    logic                         w_ready;
    logic [$clog2(ARR_HGT)-1:0]   w_row_sel;
    logic                         preload;
    logic                         switch;
    logic                         in_valid;
    logic                         in_ready;
    logic [ARR_HGT*WORD_LEN-1:0]  in_data;
    logic [ARR_HGT*WORD_LEN-1:0]  arr_in;
    logic                         out_valid;
`ifdef SYSARR_CTRL_PERF_EN
    logic [CNT_W-1:0]             stall_cnt;

    modport master (
        output start, n_vec, w_valid, in_valid, in_data,
        input  busy, done, w_ready, w_row_sel, preload, switch, in_ready, arr_in, out_valid,
               stall_cnt
    );
    modport slave (
        input  start, n_vec, w_valid, in_valid, in_data,
        output busy, done, w_ready, w_row_sel, preload, switch, in_ready, arr_in, out_valid,
               stall_cnt
    );
`else
    modport master (
        output start, n_vec, w_valid, in_valid, in_data,
        input  busy, done, w_ready, w_row_sel, preload, switch, in_ready, arr_in, out_valid
    );
    modport slave (
        input  start, n_vec, w_valid, in_valid, in_data,
        output busy, done, w_ready, w_row_sel, preload, switch, in_ready, arr_in, out_valid
    );
`endif
endinterface

// File: rtl/sysarr_vld_pipe.sv
// LAT-deep valid shift register that follows each accepted vector through the array.
module sysarr_vld_pipe #(
    parameter int unsigned LAT = 7
) (
    input  logic clk,
    input  logic nrst,
    input  logic vld,
    output logic vld_dly
);
    logic [LAT-1:0] pipe_q;

    // Cast keeps the low LAT bits, i.e. a left shift with vld entering bit 0.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= LAT'({pipe_q, vld});
        end
    end

    assign vld_dly = pipe_q[LAT-1];

endmodule

// File: rtl/sysarr_ctrl.sv
// Job sequencer for the weight-stationary systolic array: weight preload, swap, vector stream
// and drain. Define SYSARR_CTRL_PERF_EN to add the stall_cnt performance counter.
module sysarr_ctrl
    import sysarr_defs::*;
#(
    parameter int unsigned WORD_LEN = WORD_LEN_DEF,
    parameter int unsigned ARR_WDT  = ARR_WDT_DEF,
    parameter int unsigned ARR_HGT  = ARR_HGT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         nrst,
    sysarr_ctrl_if.slave bus
);
    localparam int unsigned LAT   = calc_lat(ARR_HGT, ARR_WDT);
    localparam int unsigned ROW_W = $clog2(ARR_HGT);
    localparam int unsigned DRN_W = $clog2(LAT + 1);

    sysarr_state_e               state_q, state_d;
    logic [CNT_W-1:0]            n_vec_q, n_vec_d;
    logic [CNT_W-1:0]            vec_q, vec_d;
    logic [ROW_W-1:0]            row_q, row_d;
    logic [DRN_W-1:0]            drn_q, drn_d;
    logic [ARR_HGT*WORD_LEN-1:0] arr_in_q, arr_in_d;
    logic                        accept;
    logic                        out_valid;

    always_comb begin
        state_d      = state_q;
        n_vec_d      = n_vec_q;
        vec_d        = vec_q;
        row_d        = row_q;
        drn_d        = drn_q;
        arr_in_d     = '0;
        accept       = 1'b0;
        bus.busy     = (state_q != StIdle);
        bus.done     = 1'b0;
        bus.w_ready  = 1'b0;
        bus.preload  = 1'b0;
        bus.switch   = 1'b0;
        bus.in_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StLoad;
                    n_vec_d = bus.n_vec;
                    vec_d   = '0;
                    row_d   = '0;
                end
            end
            StLoad: begin
                bus.w_ready = 1'b1;
                bus.preload = bus.w_valid;
                if (bus.w_valid) begin
                    if (row_q == ROW_W'(ARR_HGT - 1)) begin
                        row_d   = '0;
                        state_d = StSwap;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            StSwap: begin
                bus.switch = 1'b1;
                if (n_vec_q == '0) begin
                    state_d = StDrain;
                    drn_d   = DRN_W'(LAT);
                end else begin
                    state_d = StStream;
                end
            end
            StStream: begin
                // The array has no back-pressure, so a missing vector becomes a zero bubble.
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept   = 1'b1;
                    arr_in_d = bus.in_data;
                    vec_d    = vec_q + CNT_W'(1);
                    if (vec_q == n_vec_q - CNT_W'(1)) begin
                        state_d = StDrain;
                        drn_d   = DRN_W'(LAT);
                    end
                end
            end
            StDrain: begin
                if (drn_q == '0) begin
                    bus.done = 1'b1;
                    state_d  = StIdle;
                end else begin
                    drn_d = drn_q - DRN_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= StIdle;
            n_vec_q  <= '0;
            vec_q    <= '0;
            row_q    <= '0;
            drn_q    <= '0;
            arr_in_q <= '0;
        end else begin
            state_q  <= state_d;
            n_vec_q  <= n_vec_d;
            vec_q    <= vec_d;
            row_q    <= row_d;
            drn_q    <= drn_d;
            arr_in_q <= arr_in_d;
        end
    end

    sysarr_vld_pipe #(
        .LAT (LAT)
    ) u_vld_pipe (
        .clk     (clk),
        .nrst    (nrst),
        .vld     (accept),
        .vld_dly (out_valid)
    );

    assign bus.w_row_sel = row_q;
    assign bus.arr_in    = arr_in_q;
    assign bus.out_valid = out_valid;

`ifdef SYSARR_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == StIdle && bus.start) begin
            stall_d = '0;
        end else if (state_q == StStream && !bus.in_valid && stall_q != '1) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sysarr_ctrl.sv
// Self-checking bench for sysarr_ctrl: job table plus random jobs checked cycle by cycle
// against a timeline model derived from the stimulus.
module tb_sysarr_ctrl;
    import sysarr_defs::*;

    localparam int LAT  = ARR_HGT_DEF + ARR_WDT_DEF - 1;
    localparam int DW   = ARR_HGT_DEF * WORD_LEN_DEF;
    localparam int CW   = CNT_W_DEF;
    localparam int MAXC = 160;
    localparam int NS   = 9;

    typedef struct {
        int          nv;
        logic [15:0] wm;
        logic [15:0] im;
        bit          spam;
        int          exp_dn;
        int          exp_nov;
        int          exp_stall;
    } job_t;

    logic clk = 1'b0;
    logic nrst;
    int   errs = 0;
    int   checks = 0;

    sysarr_ctrl_if bus ();

    sysarr_ctrl u_dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    bit          w_v_s [MAXC];
    bit          i_v_s [MAXC];
    bit          st_s  [MAXC];
    logic [DW-1:0] d_s [MAXC];
    logic [CW-1:0] nv_s [MAXC];
    int          act_t [NS][MAXC];
    int          exp_t [NS][MAXC];
    string       names [NS] = '{"busy", "done", "w_ready", "preload", "w_row_sel", "switch",
                                "in_ready", "arr_in", "out_valid"};

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int outs_vec();
        logic [24:0] v;
        v = {bus.busy, bus.done, bus.w_ready, bus.preload, bus.switch, bus.in_ready,
             bus.out_valid, bus.w_row_sel, bus.arr_in};
        return int'(v);
    endfunction

    // Stimulus: masks give the first 16 cycles of w_valid (from cycle 1) and in_valid (from the
    // first stream cycle); later cycles are 1, or random up to cycle 100 when rnd is set.
    task automatic fill_stim(input int nv, input logic [15:0] wm, input logic [15:0] im,
                             input bit rnd);
        int cnt, sw;
        cnt = 0;
        sw  = 0;
        for (int k = 0; k < MAXC; k++) begin
            w_v_s[k] = (k >= 1 && k <= 16) ? wm[k-1] : 1'b1;
            if (rnd && k < 100) w_v_s[k] = ($urandom_range(0, 3) != 0);
            if (k >= 1 && sw == 0 && w_v_s[k]) begin
                cnt++;
                if (cnt == ARR_HGT_DEF) sw = k + 1;
            end
            d_s[k]  = DW'($urandom) | DW'(1);
            nv_s[k] = CW'($urandom);
            st_s[k] = (k == 0);
        end
        for (int k = 0; k < MAXC; k++) begin
            i_v_s[k] = (k > sw && k - sw - 1 < 16) ? im[k-sw-1] : 1'b1;
            if (rnd && k < 100) i_v_s[k] = ($urandom_range(0, 2) != 0);
        end
        if (nv < 0) $fatal(1, "FAIL fill_stim: bad n_vec");
    endtask

    // Timeline model: 4 weight handshakes, one swap cycle, n_vec accepts, LAT-cycle drain.
    task automatic model(input int nv, output int dn, output int stall);
        int cnt, lw, sw, alast, acc;
        bit acc_at [MAXC];
        cnt = 0;
        lw  = 0;
        for (int k = 1; k < MAXC; k++) begin
            if (w_v_s[k]) begin
                cnt++;
                if (cnt == ARR_HGT_DEF) begin
                    lw = k;
                    break;
                end
            end
        end
        sw    = lw + 1;
        alast = sw;
        acc   = 0;
        stall = 0;
        for (int k = 0; k < MAXC; k++) acc_at[k] = 1'b0;
        if (nv > 0) begin
            for (int k = sw + 1; k < MAXC; k++) begin
                if (i_v_s[k]) begin
                    acc_at[k] = 1'b1;
                    acc++;
                    if (acc == nv) begin
                        alast = k;
                        break;
                    end
                end else begin
                    stall++;
                end
            end
        end
        dn  = alast + LAT + 1;
        cnt = 0;
        for (int k = 0; k < MAXC; k++) begin
            bit ld, st;
            ld = (k >= 1 && k <= lw);
            st = (nv > 0 && k > sw && k <= alast);
            exp_t[0][k] = (k >= 1 && k <= dn) ? 1 : 0;
            exp_t[1][k] = (k == dn) ? 1 : 0;
            exp_t[2][k] = ld ? 1 : 0;
            exp_t[3][k] = (ld && w_v_s[k]) ? 1 : 0;
            exp_t[4][k] = ld ? cnt : 0;
            if (ld && w_v_s[k]) cnt++;
            exp_t[5][k] = (k == sw) ? 1 : 0;
            exp_t[6][k] = st ? 1 : 0;
            exp_t[7][k] = (k >= 1 && acc_at[k-1]) ? int'(d_s[k-1]) : 0;
            exp_t[8][k] = (k >= LAT && acc_at[k-LAT]) ? 1 : 0;
        end
    endtask

    task automatic run_job(input int nv, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            bus.start    = st_s[k];
            bus.n_vec    = (k == 0) ? CW'(nv) : nv_s[k];
            bus.w_valid  = w_v_s[k];
            bus.in_valid = i_v_s[k];
            bus.in_data  = d_s[k];
            #1;
            act_t[0][k] = int'(bus.busy);
            act_t[1][k] = int'(bus.done);
            act_t[2][k] = int'(bus.w_ready);
            act_t[3][k] = int'(bus.preload);
            act_t[4][k] = int'(bus.w_row_sel);
            act_t[5][k] = int'(bus.switch);
            act_t[6][k] = int'(bus.in_ready);
            act_t[7][k] = int'(bus.arr_in);
            act_t[8][k] = int'(bus.out_valid);
        end
        bus.start = 1'b0;
    endtask

    task automatic compare_trace(input string tag, input int ncyc);
        for (int s = 0; s < NS; s++) begin
            int nmis, first;
            nmis  = 0;
            first = 0;
            for (int k = 0; k < ncyc; k++) begin
                if (act_t[s][k] != exp_t[s][k]) begin
                    if (nmis == 0) first = k;
                    nmis++;
                end
            end
            checks++;
            if (nmis != 0) begin
                errs++;
                $display("FAIL %s %s: %0d bad cycles, first at cycle %0d got %0d expected %0d",
                         tag, names[s], nmis, first, act_t[s][first], exp_t[s][first]);
            end
        end
    endtask

    task automatic do_job(input string tag, input int nv, input logic [15:0] wm,
                          input logic [15:0] im, input bit rnd, input bit spam,
                          output int dn_act, output int nov_act, output int stall_act);
        int dn, stall, ncyc;
        fill_stim(nv, wm, im, rnd);
        model(nv, dn, stall);
        // Start pulses while busy (including the done cycle) must be ignored.
        for (int k = 1; k < MAXC; k++)
            st_s[k] = (k <= dn) && (spam || (rnd && $urandom_range(0, 7) == 0));
        ncyc = dn + 4;
        run_job(nv, ncyc);
        compare_trace(tag, ncyc);
        dn_act  = -1;
        nov_act = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (act_t[1][k] != 0 && dn_act < 0) dn_act = k;
            nov_act += act_t[8][k];
        end
        stall_act = 0;
`ifdef SYSARR_CTRL_PERF_EN
        stall_act = int'(bus.stall_cnt);
        check({tag, " stall_cnt"}, stall_act, stall);
`endif
    endtask

    initial begin
        job_t tbl [5];
        int   dn_a, nov_a, st_a, bad;
        tbl[0] = '{nv: 3, wm: 16'hFFFF, im: 16'hFFFF, spam: 1'b0, exp_dn: 16, exp_nov: 3,
                   exp_stall: 0};
        tbl[1] = '{nv: 3, wm: 16'hFFF3, im: 16'hFFFF, spam: 1'b0, exp_dn: 18, exp_nov: 3,
                   exp_stall: 0};
        tbl[2] = '{nv: 3, wm: 16'hFFFF, im: 16'hFFF5, spam: 1'b0, exp_dn: 18, exp_nov: 3,
                   exp_stall: 2};
        tbl[3] = '{nv: 0, wm: 16'hFFFF, im: 16'hFFFF, spam: 1'b0, exp_dn: 13, exp_nov: 0,
                   exp_stall: 0};
        tbl[4] = '{nv: 2, wm: 16'hFFFF, im: 16'hFFFF, spam: 1'b1, exp_dn: 15, exp_nov: 2,
                   exp_stall: 0};

        nrst         = 1'b0;
        bus.start    = 1'b0;
        bus.n_vec    = '0;
        bus.w_valid  = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(negedge clk);
        #1 check("reset outputs", outs_vec(), 0);
        nrst = 1'b1;

        for (int j = 0; j < 5; j++) begin
            string tag;
            tag = $sformatf("tbl%0d", j);
            do_job(tag, tbl[j].nv, tbl[j].wm, tbl[j].im, 1'b0, tbl[j].spam, dn_a, nov_a, st_a);
            check({tag, " done cycle"}, dn_a, tbl[j].exp_dn);
            check({tag, " out_valid count"}, nov_a, tbl[j].exp_nov);
`ifdef SYSARR_CTRL_PERF_EN
            check({tag, " stall_cnt table"}, st_a, tbl[j].exp_stall);
`endif
        end

        // Reset in the middle of STREAM: outputs drop at once and the job never completes.
        fill_stim(5, 16'hFFFF, 16'hFFFF, 1'b0);
        run_job(5, 8);
        @(negedge clk);
        #2 nrst = 1'b0;
        #1 check("async reset mid-stream", outs_vec(), 0);
        repeat (2) @(negedge clk);
        #1 nrst = 1'b1;
        bus.in_valid = 1'b0;
        bus.w_valid  = 1'b0;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1 if (bus.done || bus.busy) bad++;
        end
        check("no done/busy after abort", bad, 0);
        do_job("post-reset", 3, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, dn_a, nov_a, st_a);
        check("post-reset done cycle", dn_a, 16);

        for (int j = 0; j < 20; j++) begin
            do_job($sformatf("rnd%0d", j), int'($urandom_range(0, 12)), 16'hFFFF, 16'hFFFF,
                   1'b1, 1'b0, dn_a, nov_a, st_a);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
